rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (we3/wa3/wd3) between two sources: the pipeline writeback stage (W) and a multicycle multiply/divide unit (MDU) that retires results out of order.
- W has priority. A starvation counter forces an MDU grant by requesting a one-cycle pipeline freeze.
- A 32-entry pending scoreboard tracks registers awaiting an MDU result and reports busy flags to the hazard unit.

Parameters:
- STARVE_LIMIT, 4, consecutive denied MDU cycles tolerated before a forced grant (legal range 1..15).
- CNT_W, 4, width of the starvation counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_we  in  1  W-stage write request.
- wb_wa  in  5  W-stage destination register.
- wb_wd  in  32  W-stage write data.
- mdu_valid  in  1  MDU result valid.
- mdu_wa  in  5  MDU destination register.
- mdu_wd  in  32  MDU result data.
- mdu_ready  out  1  MDU result accepted this cycle.
- mdu_issue  in  1  decode issues an MDU op this cycle.
- mdu_issue_wa  in  5  destination of the issued MDU op.
- ra1, ra2  in  5  source registers queried by the hazard unit.
- busy1, busy2  out  1  the queried register has a pending MDU write.
- stall_req  out  1  registered; freeze the pipeline this cycle.
- we3  out  1  register file write enable.
- wa3  out  5  register file write address.
- wd3  out  32  register file write data.

Behaviour:
- Reset: state=NORMAL, counter=0, pending=0, stall_req=0. While reset is high, we3=0, mdu_ready=0, busy1=busy2=0.
- Write port is combinational from the current state and inputs. The register file samples it later in the same cycle, so write latency is 0 cycles.
- State machine, two states:
  - NORMAL:
    - If wb_we=1: W is granted (we3=1, wa3=wb_wa, wd3=wb_wd) and mdu_ready=0.
    - Else if mdu_valid=1: MDU is granted (mdu_ready=1, we3=1, wa3=mdu_wa, wd3=mdu_wd).
    - Else we3=0.
  - STALL:
    - stall_req=1.
    - wb_we is ignored. The hazard unit holds W and re-presents the same write in a later cycle.
    - mdu_ready=mdu_valid, and the write port carries the MDU write.
- Counter:
  - In NORMAL with mdu_valid=1 and mdu_ready=0, the counter increments.
  - Any MDU transfer (mdu_valid and mdu_ready both 1) clears it.
  - mdu_valid=0 clears it.
- Transitions:
  - NORMAL to STALL when the counter equals STARVE_LIMIT-1 and the MDU is denied this cycle.
  - STALL to NORMAL after one cycle, unconditionally.
  - The counter is cleared on entry to STALL.
- Handshake: once mdu_valid is asserted, mdu_valid, mdu_wa and mdu_wd stay stable until mdu_ready=1. If mdu_valid is low while in STALL, no write occurs and the state returns to NORMAL.
- Register 0: a write with wa=0 from either source is granted (ready/transfer behave normally) but drives we3=0.
- Scoreboard (pending[31:0]):
  - On mdu_issue with mdu_issue_wa≠0, the pending bit is set.
  - On an MDU transfer, pending[mdu_wa] is cleared.
  - Set and clear of the same register in the same cycle: set wins.
  - pending[0] is always 0.
  - busy1=pending[ra1] and busy2=pending[ra2], combinational from registered state. An issue is visible from the next cycle; a clear is visible from the next cycle.
- Reset asserted mid-STALL: the next state is NORMAL, and all pending bits are dropped.

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt (16 bits): counts cycles spent in STALL.
  - mdu_grant_cnt (16 bits): counts MDU transfers.
- Both counters saturate at 16'hFFFF and clear on reset.
- When the macro is not defined, these ports and their registers do not exist, and the block's behaviour is otherwise identical.

Test Plan:
- wb_we=1, wb_wa=5, wb_wd=32'hDEAD_BEEF, mdu_valid=0 -> we3=1, wa3=5, wd3=DEADBEEF, mdu_ready=0, stall_req stays 0.
- mdu_valid=1, wa=7, wd=32'h1234, wb_we=0 -> mdu_ready=1 same cycle, we3=1, wa3=7. With pending[7] set beforehand, busy1 (ra1=7) drops to 0 the following cycle.
- STARVE_LIMIT=4, wb_we=1 every cycle, mdu_valid=1 -> mdu_ready=0 for 4 cycles, stall_req=1 in the 5th with MDU written and wb_we ignored, then back to a W grant.
- mdu_issue=1 with wa=9 while an MDU transfer retires wa=9 in the same cycle -> pending[9]=1 afterwards and busy2=1 for ra2=9. A write or issue with wa=0 gives we3=0 and busy flags 0.
- Reset asserted while in STALL with pending=32'h0000_0300 -> next cycle stall_req=0, busy flags 0, counter 0. A fresh MDU request is granted normally.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between writeback and the MDU, with a starvation-forced stall and a pending scoreboard.
// Optional stall/grant statistics counters are enabled by defining RF_ARB_STATS_EN.
module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef RF_ARB_STATS_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] mdu_grant_cnt,
`endif
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_wa,
    input  logic [31:0] mdu_wd,
    output logic        mdu_ready,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_wa,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        busy1,
    output logic        busy2,
    output logic        stall_req,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3
);
    typedef enum logic {NORMAL, STALL} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0] pending, pend_n;
    logic wb_grant, transfer, denied;
    always_comb begin
        wb_grant  = !reset && state == NORMAL && wb_we;
        mdu_ready = !reset && mdu_valid && (state == STALL || !wb_we);
        transfer  = mdu_valid && mdu_ready;
        denied    = state == NORMAL && mdu_valid && !mdu_ready;
        wa3       = wb_grant ? wb_wa : mdu_wa;
        wd3       = wb_grant ? wb_wd : mdu_wd;
        // r0 writes still complete the handshake but never reach the array
        we3       = (wb_grant || mdu_ready) && wa3 != 5'd0;
        state_n   = denied && cnt == CNT_W'(STARVE_LIMIT - 1) ? STALL : NORMAL;
        cnt_n     = denied && state_n == NORMAL ? cnt + 1'b1 : '0;
        // issue is applied after the retire clear so a same-register set wins
        pend_n    = (pending & ~(transfer ? 32'd1 << mdu_wa : 32'd0))
                  | (mdu_issue ? 32'd1 << mdu_issue_wa : 32'd0);
        pend_n[0] = 1'b0;
        busy1     = !reset && pending[ra1];
        busy2     = !reset && pending[ra2];
    end
    assign stall_req = state == STALL;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= NORMAL;
            cnt     <= '0;
            pending <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= pend_n;
        end
    end
`ifdef RF_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt     <= '0;
            mdu_grant_cnt <= '0;
        end else begin
            if (state == STALL && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (transfer && mdu_grant_cnt != 16'hFFFF) mdu_grant_cnt <= mdu_grant_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed checks of write-port arbitration, starvation stall and scoreboard.
module tb_rf_write_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic wb_we = 0, mdu_valid = 0, mdu_issue = 0;
    logic [4:0] wb_wa = 0, mdu_wa = 0, mdu_issue_wa = 0, ra1 = 0, ra2 = 0;
    logic [31:0] wb_wd = 0, mdu_wd = 0;
    logic mdu_ready, busy1, busy2, stall_req, we3;
    logic [4:0] wa3;
    logic [31:0] wd3;
`ifdef RF_ARB_STATS_EN
    logic [15:0] stall_cnt, mdu_grant_cnt;
`endif
    int checks = 0, errors = 0;

    rf_write_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
`ifdef RF_ARB_STATS_EN
        .stall_cnt(stall_cnt), .mdu_grant_cnt(mdu_grant_cnt),
`endif
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .mdu_valid(mdu_valid), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
        .mdu_issue(mdu_issue), .mdu_issue_wa(mdu_issue_wa),
        .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2),
        .stall_req(stall_req), .we3(we3), .wa3(wa3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        wb_we = 1; mdu_valid = 1; mdu_wa = 3; ra1 = 3;
        tick; tick;
        chk("rst_we3", we3, 0);
        chk("rst_ready", mdu_ready, 0);
        chk("rst_busy1", busy1, 0);
        reset = 0; wb_we = 0; mdu_valid = 0;
        tick;
        chk("rst_stall", stall_req, 0);
        chk("idle_we3", we3, 0);

        wb_we = 1; wb_wa = 5; wb_wd = 32'hDEAD_BEEF; #1;
        chk("wb_we3", we3, 1);
        chk("wb_wa3", wa3, 5);
        chk("wb_wd3", wd3, 32'hDEAD_BEEF);
        chk("wb_ready", mdu_ready, 0);
        tick;
        chk("wb_stall", stall_req, 0);

        wb_we = 0; mdu_issue = 1; mdu_issue_wa = 7; ra1 = 7;
        tick;
        chk("issue7_busy1", busy1, 1);
        mdu_issue_wa = 0; ra2 = 0;
        tick;
        chk("issue0_busy2", busy2, 0);
        mdu_issue = 0;

        mdu_valid = 1; mdu_wa = 7; mdu_wd = 32'h1234; #1;
        chk("mdu_ready", mdu_ready, 1);
        chk("mdu_we3", we3, 1);
        chk("mdu_wa3", wa3, 7);
        chk("mdu_wd3", wd3, 32'h1234);
        chk("busy1_same_cycle", busy1, 1);
        tick;
        mdu_valid = 0; #1;
        chk("busy1_cleared", busy1, 0);

        wb_we = 1; wb_wa = 3; wb_wd = 32'hAAAA; mdu_valid = 1; mdu_wa = 8; mdu_wd = 32'hBBBB; #1;
        for (int i = 0; i < 4; i++) begin
            chk("starve_ready", mdu_ready, 0);
            chk("starve_wa3", wa3, 3);
            chk("starve_stall", stall_req, 0);
            tick;
        end
        chk("stall_req", stall_req, 1);
        chk("stall_ready", mdu_ready, 1);
        chk("stall_we3", we3, 1);
        chk("stall_wa3", wa3, 8);
        chk("stall_wd3", wd3, 32'hBBBB);
        tick;
        mdu_valid = 0; #1;
        chk("post_stall_req", stall_req, 0);
        chk("post_stall_wa3", wa3, 3);
        chk("post_stall_wd3", wd3, 32'hAAAA);
        wb_we = 0;

        mdu_issue = 1; mdu_issue_wa = 9; ra2 = 9;
        tick;
        mdu_valid = 1; mdu_wa = 9; mdu_wd = 32'h99; #1;
        chk("setclr_ready", mdu_ready, 1);
        tick;
        mdu_valid = 0; mdu_issue = 0; #1;
        chk("set_wins_busy2", busy2, 1);
        mdu_valid = 1; #1;
        tick;
        mdu_valid = 0; #1;
        chk("clear9_busy2", busy2, 0);

        wb_we = 1; wb_wa = 0; #1;
        chk("wb_r0_we3", we3, 0);
        wb_we = 0; mdu_valid = 1; mdu_wa = 0; #1;
        chk("mdu_r0_ready", mdu_ready, 1);
        chk("mdu_r0_we3", we3, 0);
        tick;
        mdu_valid = 0;

        mdu_issue = 1; mdu_issue_wa = 8;
        tick;
        mdu_issue_wa = 9;
        tick;
        mdu_issue = 0; ra1 = 8; ra2 = 9; #1;
        chk("pend8", busy1, 1);
        chk("pend9", busy2, 1);
        wb_we = 1; wb_wa = 2; mdu_valid = 1; mdu_wa = 4; mdu_wd = 32'h44;
        repeat (4) tick;
        chk("pre_rst_stall", stall_req, 1);
        reset = 1;
        tick;
        reset = 0; #1;
        chk("rst_stall_req", stall_req, 0);
        chk("rst_busy1_drop", busy1, 0);
        chk("rst_busy2_drop", busy2, 0);
        for (int i = 0; i < 4; i++) begin
            chk("cnt_zero_no_stall", stall_req, 0);
            tick;
        end
        chk("cnt_zero_stall", stall_req, 1);
        tick;
        wb_we = 0; #1;
        chk("fresh_ready", mdu_ready, 1);
        chk("fresh_wa3", wa3, 4);
        tick;
        mdu_valid = 0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
